// File: rtl/lm_sm_sequencer.sv
// ---------------------------------------------------------------------------
// lm_sm_sequencer
//
// Register-transfer sequencer for load-multiple / store-multiple. A register
// mask is walked lowest index first; each pending transfer is presented as a
// 3-bit register index plus a memory address that increments per transfer.
// The control FSM starts a sequence with `start` and steps it with `advance`
// once per completed memory transfer.
//
// Ports:
//   clk        rising-edge system clock
//   rst_n      synchronous active-low reset
//   start      begin a sequence (sampled in IDLE only)
//   mask       register mask, bit i set = transfer Ri (sampled with start)
//   base_addr  first memory address (sampled with start)
//   advance    current transfer complete (honoured only while valid)
//   busy       high in ACTIVE and DONE
//   valid      reg_idx / mem_addr describe a pending transfer
//   reg_idx    index of the lowest set bit of the pending mask
//   mem_addr   address of the current transfer
//   done       one-cycle pulse when the sequence finishes
//   count      transfers completed in the current / last sequence
// ---------------------------------------------------------------------------
module lm_sm_sequencer #(
  parameter int MASK_W = 8,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MASK_W-1:0] mask,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              advance,
  output logic              busy,
  output logic              valid,
  output logic [2:0]        reg_idx,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              done,
  output logic [CNT_W-1:0]  count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Index of the least-significant set bit; 0 when the mask is empty.
  function automatic logic [2:0] lsb_index(input logic [MASK_W-1:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (m[i]) begin
        idx = i[2:0];
      end
    end
    return idx;
  endfunction

  logic [1:0]        state_r;
  logic [MASK_W-1:0] pending_r;
  logic [ADDR_W-1:0] addr_r;
  logic [CNT_W-1:0]  count_r;

  logic              busy_r;
  logic              valid_r;
  logic              done_r;
  logic [2:0]        reg_idx_r;

  logic [1:0]        state_nx_s;
  logic [MASK_W-1:0] pending_nx_s;
  logic [ADDR_W-1:0] addr_nx_s;
  logic [CNT_W-1:0]  count_nx_s;
  logic [MASK_W-1:0] pending_clr_s;

  // Dropping the lowest set bit: m & (m-1) clears exactly the bit lsb_index points at.
  always_comb begin
    pending_clr_s = pending_r & (pending_r - {{(MASK_W-1){1'b0}}, 1'b1});
  end

  // Next-state and datapath update for the sequencer FSM.
  always_comb begin
    state_nx_s   = state_r;
    pending_nx_s = pending_r;
    addr_nx_s    = addr_r;
    count_nx_s   = count_r;
    case (state_r)
      ST_IDLE: begin
        // start wins over a simultaneous advance, which is meaningless here.
        if (start) begin
          pending_nx_s = mask;
          addr_nx_s    = base_addr;
          count_nx_s   = {CNT_W{1'b0}};
          if (mask != {MASK_W{1'b0}}) begin
            state_nx_s = ST_ACTIVE;
          end else begin
            state_nx_s = ST_DONE;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (advance) begin
          pending_nx_s = pending_clr_s;
          addr_nx_s    = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          count_nx_s   = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (pending_clr_s == {MASK_W{1'b0}}) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_ACTIVE;
          end
        end else begin
          state_nx_s = ST_ACTIVE;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State registers plus output flops; outputs are computed from the next
  // state so they line up with the state they describe, with no input-to-output path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      pending_r <= {MASK_W{1'b0}};
      addr_r    <= {ADDR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      busy_r    <= 1'b0;
      valid_r   <= 1'b0;
      done_r    <= 1'b0;
      reg_idx_r <= 3'd0;
    end else begin
      state_r   <= state_nx_s;
      pending_r <= pending_nx_s;
      addr_r    <= addr_nx_s;
      count_r   <= count_nx_s;
      busy_r    <= (state_nx_s == ST_ACTIVE) || (state_nx_s == ST_DONE);
      valid_r   <= (state_nx_s == ST_ACTIVE);
      done_r    <= (state_nx_s == ST_DONE);
      if (state_nx_s == ST_ACTIVE) begin
        reg_idx_r <= lsb_index(pending_nx_s);
      end else begin
        reg_idx_r <= 3'd0;
      end
    end
  end

  assign busy     = busy_r;
  assign valid    = valid_r;
  assign done     = done_r;
  assign reg_idx  = reg_idx_r;
  assign mem_addr = addr_r;
  assign count    = count_r;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lm_sm_sequencer
//
// Self-checking bench for lm_sm_sequencer. Expected transfer lists are built
// from the mask by a simple bit-walk model (ascending set bits, address
// base + k modulo 2^16), then compared cycle by cycle with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_lm_sm_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  mask;
  logic [15:0] base_addr;
  logic        advance;
  logic        busy;
  logic        valid;
  logic [2:0]  reg_idx;
  logic [15:0] mem_addr;
  logic        done;
  logic [3:0]  count;

  int checks;
  int failures;

  lm_sm_sequencer #(.MASK_W(8), .ADDR_W(16), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mask      (mask),
    .base_addr (base_addr),
    .advance   (advance),
    .busy      (busy),
    .valid     (valid),
    .reg_idx   (reg_idx),
    .mem_addr  (mem_addr),
    .done      (done),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step one clock edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    mask = 8'($urandom);
    base_addr = 16'($urandom);
    advance = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, valid, done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags busy/valid/done got %b expected 000", {busy, valid, done});
    end
    checks++;
    if (reg_idx !== 3'd0 || mem_addr !== 16'h0000 || count !== 4'd0) begin
      failures++;
      $display("FAIL reset_data idx=%0d addr=%h count=%0d expected 0/0000/0", reg_idx, mem_addr, count);
    end
    rst_n = 1'b1;
    start = 1'b0;
    advance = 1'b0;
    tick();
    checks++;
    if ({busy, valid, done} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset busy/valid/done got %b expected 000", {busy, valid, done});
    end
  endtask

  // Runs directed and random sequences; random stalls and stray start /
  // advance pulses exercise the "ignored" cases.
  task automatic test_transfer_sequences(input int n_random);
    logic [7:0]  tbl_mask [0:3];
    logic [15:0] tbl_base [0:3];
    int          exp_idx [$];
    logic [15:0] exp_addr [$];
    logic [7:0]  m;
    logic [15:0] b;
    int          stall_max;
    int          stall;
    tbl_mask[0] = 8'b1010_0101; tbl_base[0] = 16'h0010;
    tbl_mask[1] = 8'hFF;        tbl_base[1] = 16'hFFFE;
    tbl_mask[2] = 8'h00;        tbl_base[2] = 16'h4321;
    tbl_mask[3] = 8'h80;        tbl_base[3] = 16'hFFFF;
    for (int t = 0; t < 4 + n_random; t++) begin
      if (t < 4) begin
        m = tbl_mask[t];
        b = tbl_base[t];
        stall_max = 0;
      end else begin
        m = 8'($urandom);
        if ($urandom_range(0, 7) == 0) m = 8'h00;
        b = 16'($urandom);
        stall_max = 3;
      end
      exp_idx.delete();
      exp_addr.delete();
      for (int i = 0; i < 8; i++) begin
        if (m[i]) begin
          exp_addr.push_back(b + 16'(exp_idx.size()));
          exp_idx.push_back(i);
        end
      end
      start = 1'b1;
      mask = m;
      base_addr = b;
      advance = 1'($urandom);
      tick();
      start = 1'b0;
      for (int k = 0; k < exp_idx.size(); k++) begin
        stall = (stall_max == 0) ? 0 : $urandom_range(0, stall_max);
        for (int s = 0; s <= stall; s++) begin
          checks++;
          if (valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL seq%0d_flags k=%0d valid/busy/done got %b%b%b expected 110", t, k, valid, busy, done);
          end
          checks++;
          if (reg_idx !== 3'(exp_idx[k]) || mem_addr !== exp_addr[k] || count !== 4'(k)) begin
            failures++;
            $display("FAIL seq%0d_xfer k=%0d got idx=%0d addr=%h count=%0d expected idx=%0d addr=%h count=%0d",
                     t, k, reg_idx, mem_addr, count, exp_idx[k], exp_addr[k], k);
          end
          advance = (s == stall);
          // A stray start mid-sequence must have no effect.
          start = (s != stall) ? 1'($urandom) : 1'b0;
          mask = 8'($urandom);
          base_addr = 16'($urandom);
          tick();
        end
        start = 1'b0;
      end
      checks++;
      if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b1 || count !== 4'(exp_idx.size())) begin
        failures++;
        $display("FAIL seq%0d_done done/valid/busy got %b%b%b count=%0d expected 101 count=%0d",
                 t, done, valid, busy, count, exp_idx.size());
      end
      advance = 1'($urandom);
      tick();
      advance = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0 || count !== 4'(exp_idx.size())) begin
        failures++;
        $display("FAIL seq%0d_idle busy/done/valid got %b%b%b count=%0d expected 000 count=%0d",
                 t, busy, done, valid, count, exp_idx.size());
      end
    end
  endtask

  task automatic test_stall();
    start = 1'b1;
    mask = 8'b1000_0010;
    base_addr = 16'h1234;
    advance = 1'b0;
    tick();
    start = 1'b0;
    for (int s = 0; s < 5; s++) begin
      checks++;
      if (valid !== 1'b1 || reg_idx !== 3'd1 || mem_addr !== 16'h1234) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d valid=%b idx=%0d addr=%h expected 1/1/1234", s, valid, reg_idx, mem_addr);
      end
      tick();
    end
    advance = 1'b1;
    tick();
    checks++;
    if (valid !== 1'b1 || reg_idx !== 3'd7 || mem_addr !== 16'h1235 || count !== 4'd1) begin
      failures++;
      $display("FAIL stall_next valid=%b idx=%0d addr=%h count=%0d expected 1/7/1235/1", valid, reg_idx, mem_addr, count);
    end
    tick();
    advance = 1'b0;
    checks++;
    if (done !== 1'b1 || count !== 4'd2) begin
      failures++;
      $display("FAIL stall_done done=%b count=%0d expected 1/2", done, count);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    start = 1'b1;
    mask = 8'hF0;
    base_addr = 16'h0100;
    advance = 1'b0;
    tick();
    start = 1'b0;
    advance = 1'b1;
    tick();
    tick();
    advance = 1'b0;
    start = 1'b1;
    mask = 8'h01;
    base_addr = 16'hAAAA;
    tick();
    start = 1'b0;
    checks++;
    if (valid !== 1'b1 || reg_idx !== 3'd6 || mem_addr !== 16'h0102 || count !== 4'd2) begin
      failures++;
      $display("FAIL restart_ignored valid=%b idx=%0d addr=%h count=%0d expected 1/6/0102/2", valid, reg_idx, mem_addr, count);
    end
    advance = 1'b1;
    tick();
    checks++;
    if (reg_idx !== 3'd7 || mem_addr !== 16'h0103) begin
      failures++;
      $display("FAIL restart_last idx=%0d addr=%h expected 7/0103", reg_idx, mem_addr);
    end
    tick();
    advance = 1'b0;
    checks++;
    if (done !== 1'b1 || count !== 4'd4) begin
      failures++;
      $display("FAIL restart_done done=%b count=%0d expected 1/4", done, count);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    start = 1'b1;
    mask = 8'hFF;
    base_addr = 16'h0000;
    advance = 1'b0;
    tick();
    start = 1'b0;
    advance = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    advance = 1'b0;
    checks++;
    if ({busy, valid, done} !== 3'b000 || count !== 4'd0 || mem_addr !== 16'h0000 || reg_idx !== 3'd0) begin
      failures++;
      $display("FAIL midreset_state bvd=%b count=%0d addr=%h idx=%0d expected 000/0/0000/0",
               {busy, valid, done}, count, mem_addr, reg_idx);
    end
    tick();
    checks++;
    if ({busy, valid, done} !== 3'b000) begin
      failures++;
      $display("FAIL midreset_nodone bvd=%b expected 000", {busy, valid, done});
    end
    start = 1'b1;
    mask = 8'h06;
    base_addr = 16'h0005;
    tick();
    start = 1'b0;
    checks++;
    if (valid !== 1'b1 || reg_idx !== 3'd1 || mem_addr !== 16'h0005 || count !== 4'd0) begin
      failures++;
      $display("FAIL midreset_restart valid=%b idx=%0d addr=%h count=%0d expected 1/1/0005/0", valid, reg_idx, mem_addr, count);
    end
    advance = 1'b1;
    tick();
    tick();
    advance = 1'b0;
    checks++;
    if (done !== 1'b1 || count !== 4'd2) begin
      failures++;
      $display("FAIL midreset_done done=%b count=%0d expected 1/2", done, count);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    mask = 8'h00;
    base_addr = 16'h0000;
    advance = 1'b0;
    test_reset();
    test_transfer_sequences(40);
    test_stall();
    test_start_ignored();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
